pipe_ctrl_unit: RTL and testbench

- Parametrised successor to the single-cycle opcode decoder, for the 5-stage pipeline.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects RAW/load-use hazards and generates stall and bubble signals.
- Flushes on a taken branch resolved in EX.

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_unit_hazard.sv | 52 +++++
 rtl/pipe_ctrl_unit.sv | 165 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, decoded control bundle, forwarding selects.
package ctrl_pkg;

    localparam logic [5:0] OPC_ADD  = 6'h00;
    localparam logic [5:0] OPC_SUB  = 6'h01;
    localparam logic [5:0] OPC_AND  = 6'h02;
    localparam logic [5:0] OPC_XOR  = 6'h03;
    localparam logic [5:0] OPC_COM  = 6'h04;
    localparam logic [5:0] OPC_MUL  = 6'h05;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_LW   = 6'h10;
    localparam logic [5:0] OPC_SW   = 6'h18;
    localparam logic [5:0] OPC_BEQ  = 6'h21;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic wen;
        logic alusrc;
        logic regdst;
        logic branch;
        logic memwrite;
        logic memread;
        logic memtoreg;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    function automatic logic is_rtype(input logic [5:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND) ||
               (opc == OPC_XOR) || (opc == OPC_COM) || (opc == OPC_MUL);
    endfunction

    // rt is a source only for register-register ops, stores and branches
    function automatic logic uses_rt(input logic [5:0] opc);
        return is_rtype(opc) || (opc == OPC_SW) || (opc == OPC_BEQ);
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_hazard.sv
// Hazard detection: source/writer matching, stall, branch flush and (with CTRL_FWD_EN) forwarding selects.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            ex_wen,
    input  logic [RA_W-1:0] ex_wreg,
    input  logic            ex_branch,
    input  logic            ex_zero,
    input  logic            mem_wen,
    input  logic [RA_W-1:0] mem_wreg,
`ifdef CTRL_FWD_EN
    input  logic            ex_memread,
    output logic [1:0]      id_fwd_a,
    output logic [1:0]      id_fwd_b,
`endif
    output logic            stall,
    output logic            flush
);

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

    // Register 0 is hardwired, so it can never carry a dependency
    always_comb begin
        ex_hit_a  = ex_wen  && (ex_wreg  == id_rs) && (id_rs != '0);
        ex_hit_b  = id_uses_rt && ex_wen  && (ex_wreg  == id_rt) && (id_rt != '0);
        mem_hit_a = mem_wen && (mem_wreg == id_rs) && (id_rs != '0);
        mem_hit_b = id_uses_rt && mem_wen && (mem_wreg == id_rt) && (id_rt != '0);
    end

    assign flush = ex_branch & ex_zero;

`ifdef CTRL_FWD_EN
    assign stall = ex_memread & (ex_hit_a | ex_hit_b);

    always_comb begin
        id_fwd_a = FWD_RF;
        id_fwd_b = FWD_RF;
        if (ex_hit_a)       id_fwd_a = FWD_EXMEM;
        else if (mem_hit_a) id_fwd_a = FWD_MEMWB;
        if (ex_hit_b)       id_fwd_b = FWD_EXMEM;
        else if (mem_hit_b) id_fwd_b = FWD_MEMWB;
    end
`else
    assign stall = ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b;
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// 5-stage pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, stall/flush.
// Define CTRL_FWD_EN to add forwarding selects and reduce stalls to load-use only.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 3,
    parameter int RA_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   id_opcode,
    input  logic [RA_W-1:0]    id_rs,
    input  logic [RA_W-1:0]    id_rt,
    input  logic [RA_W-1:0]    id_rd,
    input  logic               ex_zero,
    output logic               pc_wen,
    output logic               ifid_wen,
    output logic               ifid_flush,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_wen,
    output logic               wb_memtoreg,
    output logic [RA_W-1:0]    wb_wreg
`ifdef CTRL_FWD_EN
    ,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
`endif
);

    ctrl_t              id_ctrl, id_sel;
    logic [ALUOP_W-1:0] id_aluop;
    logic [RA_W-1:0]    id_wreg;
    logic               id_uses_rt;
    logic               stall, flush, hold, kill;

    logic               ex_wen, ex_memwrite, ex_memread, ex_memtoreg;
    logic [RA_W-1:0]    ex_wreg;
    logic               mem_wen, mem_memtoreg;
    logic [RA_W-1:0]    mem_wreg;

    always_comb begin
        id_ctrl  = BUBBLE;
        id_aluop = '0;
        case (id_opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_XOR, OPC_COM, OPC_MUL: begin
                id_ctrl.wen      = 1'b1;
                id_ctrl.regdst   = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                id_aluop         = id_opcode[ALUOP_W-1:0];
            end
            OPC_ADDI: begin
                id_ctrl.wen      = 1'b1;
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                id_aluop         = id_opcode[ALUOP_W-1:0];
            end
            OPC_LW: begin
                id_ctrl.wen      = 1'b1;
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memread  = 1'b1;
                id_aluop         = id_opcode[ALUOP_W-1:0];
            end
            OPC_SW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memwrite = 1'b1;
                id_aluop         = id_opcode[ALUOP_W-1:0];
            end
            OPC_BEQ: begin
                id_ctrl.branch   = 1'b1;
                id_aluop         = ALUOP_W'(1);
            end
            default: ;
        endcase
    end

    assign id_wreg    = id_ctrl.regdst ? id_rd : id_rt;
    assign id_uses_rt = uses_rt(id_opcode);

`ifdef CTRL_FWD_EN
    logic [1:0] id_fwd_a, id_fwd_b;
`endif

    hazard_unit #(.RA_W(RA_W)) u_hazard (
        .id_uses_rt (id_uses_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_wen     (ex_wen),
        .ex_wreg    (ex_wreg),
        .ex_branch  (ex_branch),
        .ex_zero    (ex_zero),
        .mem_wen    (mem_wen),
        .mem_wreg   (mem_wreg),
`ifdef CTRL_FWD_EN
        .ex_memread (ex_memread),
        .id_fwd_a   (id_fwd_a),
        .id_fwd_b   (id_fwd_b),
`endif
        .stall      (stall),
        .flush      (flush)
    );

    // A taken branch overrides a stall so the PC can take the branch target
    assign hold       = stall & ~flush;
    assign kill       = stall | flush;
    assign pc_wen     = ~hold;
    assign ifid_wen   = ~hold;
    assign ifid_flush = flush;
    assign id_sel     = kill ? BUBBLE : id_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_wen       <= 1'b0;
            ex_alusrc    <= 1'b0;
            ex_aluop     <= '0;
            ex_branch    <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_memtoreg  <= 1'b0;
            ex_wreg      <= '0;
            mem_wen      <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_wreg     <= '0;
            wb_wen       <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_wreg      <= '0;
        end else begin
            ex_wen       <= id_sel.wen;
            ex_alusrc    <= id_sel.alusrc;
            ex_aluop     <= kill ? '0 : id_aluop;
            ex_branch    <= id_sel.branch;
            ex_memwrite  <= id_sel.memwrite;
            ex_memread   <= id_sel.memread;
            ex_memtoreg  <= id_sel.memtoreg;
            ex_wreg      <= kill ? '0 : id_wreg;
            mem_wen      <= ex_wen;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_wreg     <= ex_wreg;
            wb_wen       <= mem_wen;
            wb_memtoreg  <= mem_memtoreg;
            wb_wreg      <= mem_wreg;
        end
    end

`ifdef CTRL_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            fwd_a <= kill ? FWD_RF : id_fwd_a;
            fwd_b <= kill ? FWD_RF : id_fwd_b;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: a reference decode table and hazard model push expected
// stage outputs into per-stage queues that are popped when each stage is due.
module tb_pipe_ctrl_unit;
    import ctrl_pkg::*;

    localparam int OPC_W = 6, ALUOP_W = 3, RA_W = 5;

    typedef struct {
        logic [5:0] opc;
        logic [4:0] rs, rt, rd;
        logic       taken;
        logic       rst;
        int         grp;
    } instr_t;

    typedef struct packed {
        logic       wen, alusrc, branch, memread, memwrite, memtoreg, taken;
        logic [2:0] aluop;
        logic [4:0] wreg;
        logic [1:0] fa, fb;
    } mstage_t;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [OPC_W-1:0]   id_opcode;
    logic [RA_W-1:0]    id_rs, id_rt, id_rd;
    logic               ex_zero;
    logic               pc_wen, ifid_wen, ifid_flush, ex_alusrc, ex_branch;
    logic               mem_memread, mem_memwrite, wb_wen, wb_memtoreg;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [RA_W-1:0]    wb_wreg;
    logic [1:0]         dut_fa, dut_fb;

    always #5 clk = ~clk;

`ifdef CTRL_FWD_EN
    logic [1:0] fwd_a, fwd_b;
    assign dut_fa = fwd_a;
    assign dut_fb = fwd_b;
`else
    assign dut_fa = 2'b00;
    assign dut_fb = 2'b00;
`endif

    pipe_ctrl_unit #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_zero(ex_zero), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
        .ifid_flush(ifid_flush), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .ex_branch(ex_branch), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .wb_wen(wb_wen), .wb_memtoreg(wb_memtoreg), .wb_wreg(wb_wreg)
`ifdef CTRL_FWD_EN
        , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    instr_t  prog[$];
    exp_t    ex_q[$], mem_q[$], wb_q[$];
    mstage_t m_ex, m_mem;
    int      checks = 0, failures = 0, cyc = 0, pc = 0;
    bit      nop_pend = 0;
    int      stall_cnt[5] = '{default: 0};

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input instr_t i, input logic zero);
        id_opcode = i.opc;
        id_rs     = i.rs;
        id_rt     = i.rt;
        id_rd     = i.rd;
        ex_zero   = zero;
    endtask

    function automatic instr_t mk(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic taken = 1'b0, input int grp = 0);
        instr_t i;
        i.opc = opc; i.rs = rs; i.rt = rt; i.rd = rd; i.taken = taken; i.rst = 1'b0; i.grp = grp;
        return i;
    endfunction

    function automatic instr_t mk_rst();
        instr_t i = mk(6'h3F, 5'd0, 5'd0, 5'd0);
        i.rst = 1'b1;
        return i;
    endfunction

    function automatic mstage_t ref_decode(input instr_t i);
        mstage_t m = '0;
        m.wreg  = i.rt;
        m.taken = i.taken;
        case (i.opc)
            6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: begin
                m.wen = 1; m.memtoreg = 1; m.aluop = i.opc[2:0]; m.wreg = i.rd;
            end
            6'h08: begin m.wen = 1; m.alusrc = 1; m.memtoreg = 1; end
            6'h10: begin m.wen = 1; m.alusrc = 1; m.memread = 1; end
            6'h18: begin m.alusrc = 1; m.memwrite = 1; end
            6'h21: begin m.branch = 1; m.aluop = 3'b001; end
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic ref_uses_rt(input logic [5:0] opc);
        return (opc <= 6'h05) || (opc == 6'h18) || (opc == 6'h21);
    endfunction

    function automatic logic hit(input mstage_t w, input logic [4:0] s);
        return w.wen && (w.wreg == s) && (s != 5'd0);
    endfunction

    function automatic logic [31:0] pack_ex(input mstage_t m);
        return {23'd0, m.fa, m.fb, m.alusrc, m.branch, m.aluop};
    endfunction

    function automatic logic [31:0] pack_mem(input mstage_t m);
        return {30'd0, m.memread, m.memwrite};
    endfunction

    function automatic logic [31:0] pack_wb(input mstage_t m);
        return {25'd0, m.wen, m.memtoreg, m.wreg};
    endfunction

    initial begin
        instr_t  cur, nop;
        mstage_t d, load;
        exp_t    e;
        logic    ur, hx, hm, stall, flush;
        logic [5:0] opc_tab [11];

        opc_tab = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h10, 6'h18, 6'h21, 6'h3F};
        nop = mk(6'h3F, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b0;
        applyStimulus(nop, 1'b0);
        m_ex = '0;
        m_mem = '0;

        prog.push_back(mk_rst());
        prog.push_back(mk(6'h00, 5'd2, 5'd3, 5'd1));
        repeat (3) prog.push_back(nop);
        for (int k = 0; k < 6; k++) prog.push_back(mk(opc_tab[k], 5'd0, 5'd0, 5'(k + 1)));
        prog.push_back(mk(6'h08, 5'd0, 5'd10, 5'd0));
        prog.push_back(mk(6'h10, 5'd0, 5'd11, 5'd0));
        prog.push_back(mk(6'h18, 5'd0, 5'd0, 5'd0));
        prog.push_back(mk(6'h21, 5'd0, 5'd0, 5'd0));
        prog.push_back(mk(6'h3F, 5'd0, 5'd7, 5'd9));
        repeat (3) prog.push_back(nop);
        prog.push_back(mk(6'h10, 5'd0, 5'd3, 5'd0));
        prog.push_back(mk(6'h00, 5'd3, 5'd1, 5'd4, 1'b0, 1));
        repeat (3) prog.push_back(nop);
        prog.push_back(mk(6'h00, 5'd0, 5'd0, 5'd2));
        prog.push_back(mk(6'h01, 5'd2, 5'd2, 5'd5, 1'b0, 2));
        repeat (3) prog.push_back(nop);
        prog.push_back(mk(6'h10, 5'd0, 5'd6, 5'd0));
        prog.push_back(mk(6'h21, 5'd0, 5'd0, 5'd0, 1'b1));
        prog.push_back(mk(6'h10, 5'd6, 5'd7, 5'd0, 1'b0, 3));
        repeat (3) prog.push_back(nop);
        prog.push_back(mk(6'h08, 5'd0, 5'd0, 5'd0));
        prog.push_back(mk(6'h00, 5'd0, 5'd0, 5'd1, 1'b0, 4));
        repeat (3) prog.push_back(nop);
        prog.push_back(mk(6'h10, 5'd0, 5'd3, 5'd0));
        prog.push_back(mk(6'h00, 5'd3, 5'd1, 5'd4));
        prog.push_back(mk_rst());
        prog.push_back(mk(6'h00, 5'd2, 5'd3, 5'd1));
        repeat (3) prog.push_back(nop);
        for (int k = 0; k < 60; k++)
            prog.push_back(mk(opc_tab[$urandom_range(10)], 5'($urandom_range(3)),
                              5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1))));
        repeat (4) prog.push_back(nop);

        while (pc < prog.size() && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!rst_n) rst_n = 1'b1;

            if (ex_q.size() > 0 && ex_q[0].due == cyc) begin
                e = ex_q.pop_front();
                checkOutput("ex_stage", {23'd0, dut_fa, dut_fb, ex_alusrc, ex_branch, ex_aluop}, e.val);
            end
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                e = mem_q.pop_front();
                checkOutput("mem_stage", {30'd0, mem_memread, mem_memwrite}, e.val);
            end
            if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
                e = wb_q.pop_front();
                checkOutput("wb_stage", {25'd0, wb_wen, wb_memtoreg, wb_wreg}, e.val);
            end

            if (prog[pc].rst) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_pc_wen", {31'd0, pc_wen}, 32'd1);
                checkOutput("rst_ifid_wen", {31'd0, ifid_wen}, 32'd1);
                checkOutput("rst_ifid_flush", {31'd0, ifid_flush}, 32'd0);
                checkOutput("rst_ex", {23'd0, dut_fa, dut_fb, ex_alusrc, ex_branch, ex_aluop}, 32'd0);
                checkOutput("rst_mem", {30'd0, mem_memread, mem_memwrite}, 32'd0);
                checkOutput("rst_wb", {25'd0, wb_wen, wb_memtoreg, wb_wreg}, 32'd0);
                ex_q.delete();
                mem_q.delete();
                wb_q.delete();
                m_ex = '0;
                m_mem = '0;
                nop_pend = 0;
                pc++;
                continue;
            end

            cur = nop_pend ? nop : prog[pc];
            applyStimulus(cur, m_ex.taken);

            d  = ref_decode(cur);
            ur = ref_uses_rt(cur.opc);
            hx = hit(m_ex, cur.rs) || (ur && hit(m_ex, cur.rt));
            hm = hit(m_mem, cur.rs) || (ur && hit(m_mem, cur.rt));
`ifdef CTRL_FWD_EN
            stall = hx && m_ex.memread;
`else
            stall = hx || hm;
`endif
            flush = m_ex.branch && m_ex.taken;
            load  = (stall || flush) ? mstage_t'('0) : d;
`ifdef CTRL_FWD_EN
            if (!(stall || flush)) begin
                load.fa = hit(m_ex, cur.rs) ? 2'b10 : (hit(m_mem, cur.rs) ? 2'b01 : 2'b00);
                load.fb = !ur ? 2'b00 :
                          (hit(m_ex, cur.rt) ? 2'b10 : (hit(m_mem, cur.rt) ? 2'b01 : 2'b00));
            end
`endif

            #1;
            checkOutput("pc_wen", {31'd0, pc_wen}, {31'd0, flush || !stall});
            checkOutput("ifid_wen", {31'd0, ifid_wen}, {31'd0, flush || !stall});
            checkOutput("ifid_flush", {31'd0, ifid_flush}, {31'd0, flush});
            if (cur.grp != 0 && !pc_wen) stall_cnt[cur.grp]++;

            e.due = cyc + 1; e.val = pack_ex(load);  ex_q.push_back(e);
            e.due = cyc + 2; e.val = pack_mem(load); mem_q.push_back(e);
            e.due = cyc + 3; e.val = pack_wb(load);  wb_q.push_back(e);

            m_mem = m_ex;
            m_ex  = load;
            if (flush) begin
                if (!nop_pend) pc++;
                nop_pend = 1;
            end else if (!stall) begin
                if (nop_pend) nop_pend = 0;
                else pc++;
            end
        end

        checkOutput("program_done", pc, prog.size());
`ifdef CTRL_FWD_EN
        checkOutput("stalls_load_use", stall_cnt[1], 32'd1);
        checkOutput("stalls_raw", stall_cnt[2], 32'd0);
`else
        checkOutput("stalls_load_use", stall_cnt[1], 32'd2);
        checkOutput("stalls_raw", stall_cnt[2], 32'd2);
`endif
        checkOutput("stalls_branch", stall_cnt[3], 32'd0);
        checkOutput("stalls_r0", stall_cnt[4], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
